// File: rtl/bitfuscnn_pkg.sv
// Shared types for the output-activation compressor, the OARAM and its reader.
// The FSM state enum, the zero-run limit helper and the stored OARAM entry layout.
package bitfuscnn_pkg;

  // Index width of entries as laid out in the OARAM.
  localparam int OA_INDEX_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } oa_state_e;

  // Longest zero run one index field can describe.
  function automatic int max_run(input int index_width);
    return (1 << index_width) - 1;
  endfunction

  typedef struct packed {
    logic [7:0]                value;
    logic [OA_INDEX_WIDTH-1:0] index;
  } oaram_entry_t;

endpackage

// File: rtl/oa_compressor_if.sv
// Stream-in / OARAM-write bundle of the output-activation compressor.
// master: the dense producer (PPU drain side) and OARAM/status observer.
// slave : the compressor itself.
interface oa_compressor_if #(
  parameter int RAM_WIDTH   = 10,
  parameter int INDEX_WIDTH = 4
);
  logic                   start;
  logic [7:0]             dense_value;
  logic                   dense_valid;
  logic                   dense_last;
  logic                   dense_ready;
  logic [7:0]             oaram_value;
  logic [INDEX_WIDTH-1:0] oaram_index;
  logic [RAM_WIDTH-1:0]   oaram_address;
  logic                   oaram_write_enable;
  logic [RAM_WIDTH:0]     entry_count;
  logic                   overflow;
  logic                   done;

  modport master (
    output start, dense_value, dense_valid, dense_last,
    input  dense_ready, oaram_value, oaram_index, oaram_address,
           oaram_write_enable, entry_count, overflow, done
  );

  modport slave (
    input  start, dense_value, dense_valid, dense_last,
    output dense_ready, oaram_value, oaram_index, oaram_address,
           oaram_write_enable, entry_count, overflow, done
  );
endinterface

// File: rtl/oa_run_encoder.sv
// Combinational classifier for one dense beat against the current zero run.
// Decides whether the beat produces an OARAM entry and what the next run is.
// OA_RELU_EN: treat the byte as signed and clamp negatives to zero first.
module oa_run_encoder
  import bitfuscnn_pkg::*;
#(
  parameter int INDEX_WIDTH = 4
) (
  input  logic [7:0]             value,
  input  logic [INDEX_WIDTH-1:0] run,
  output logic                   emit,
  output logic [7:0]             emit_value,
  output logic [INDEX_WIDTH-1:0] emit_index,
  output logic [INDEX_WIDTH-1:0] next_run
);
  localparam logic [INDEX_WIDTH-1:0] MAX_RUN = INDEX_WIDTH'(max_run(INDEX_WIDTH));

  logic [7:0] v;

`ifdef OA_RELU_EN
  // In-line ReLU: 0x80..0xFF are negative and collapse to zero.
  assign v = value[7] ? 8'h00 : value;
`else
  assign v = value;
`endif

  // Nonzero -> (v, run); zero at a full run -> run-overflow entry; else extend run.
  always_comb begin
    emit       = 1'b0;
    emit_value = 8'h00;
    emit_index = run;
    next_run   = run + 1'b1;
    if (v != 8'h00) begin
      emit       = 1'b1;
      emit_value = v;
      next_run   = '0;
    end else if (run == MAX_RUN) begin
      // Run-overflow entry stands for MAX_RUN skipped zeros plus this zero.
      emit       = 1'b1;
      emit_index = MAX_RUN;
      next_run   = '0;
    end
  end
endmodule

// File: rtl/oa_compressor.sv
// Zero-run-length compressor from the PPU drain stream into the OARAM.
// Each written entry carries a value and the count of zeros skipped before it;
// trailing zeros of a channel are dropped. Writes past OARAM capacity are
// discarded and flagged by the sticky overflow bit.
// Optional macro OA_RELU_EN: signed input with in-line ReLU (see oa_run_encoder).
module oa_compressor
  import bitfuscnn_pkg::*;
#(
  parameter int RAM_WIDTH   = 10,
  parameter int INDEX_WIDTH = 4,
  parameter int TILE_SIZE   = 128
) (
  input  logic            clk,
  input  logic            reset_n,
  oa_compressor_if.slave  bus
);
  localparam int POS_W = 2 * $clog2(TILE_SIZE);
  localparam logic [RAM_WIDTH:0] CAPACITY = {1'b1, {RAM_WIDTH{1'b0}}};

  oa_state_e              state_q, state_d;
  logic                   start_fire, beat_fire, full;
  logic [INDEX_WIDTH-1:0] run_q;
  logic [RAM_WIDTH-1:0]   ptr_q;
  logic [RAM_WIDTH:0]     cnt_q;
  logic                   ovf_q;
  logic                   wr_en_q;
  logic [7:0]             wr_value_q;
  logic [INDEX_WIDTH-1:0] wr_index_q;
  logic [RAM_WIDTH-1:0]   wr_addr_q;
  logic [POS_W-1:0]       pos_q;

  logic                   enc_emit;
  logic [7:0]             enc_value;
  logic [INDEX_WIDTH-1:0] enc_index;
  logic [INDEX_WIDTH-1:0] enc_next_run;

  oa_run_encoder #(.INDEX_WIDTH(INDEX_WIDTH)) u_enc (
    .value      (bus.dense_value),
    .run        (run_q),
    .emit       (enc_emit),
    .emit_value (enc_value),
    .emit_index (enc_index),
    .next_run   (enc_next_run)
  );

  assign beat_fire = (state_q == SCAN) && bus.dense_valid;
  assign full      = (cnt_q == CAPACITY);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state; start only counts outside SCAN.
  always_comb begin
    state_d    = state_q;
    start_fire = 1'b0;
    unique case (state_q)
      IDLE, DONE: if (bus.start) begin
        state_d    = SCAN;
        start_fire = 1'b1;
      end
      SCAN: if (bus.dense_valid && bus.dense_last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Run counter, write pointer, counts and the registered OARAM write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_value_q <= '0;
      wr_index_q <= '0;
      wr_addr_q  <= '0;
      pos_q      <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (start_fire) begin
        run_q <= '0;
        ptr_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
        pos_q <= '0;
      end else if (beat_fire) begin
        run_q <= enc_next_run;
        pos_q <= pos_q + 1'b1;
        if (enc_emit) begin
          if (full) begin
            // Stream keeps draining; the entry is lost and the address holds.
            ovf_q <= 1'b1;
          end else begin
            wr_en_q    <= 1'b1;
            wr_value_q <= enc_value;
            wr_index_q <= enc_index;
            wr_addr_q  <= ptr_q;
            ptr_q      <= ptr_q + 1'b1;
            cnt_q      <= cnt_q + 1'b1;
          end
        end
      end
    end
  end

  // A channel never exceeds one tile's worth of positions.
  a_tile_len: assert property (@(posedge clk) disable iff (!reset_n)
    !(beat_fire && !bus.dense_last && (&pos_q)));

  assign bus.dense_ready        = (state_q == SCAN);
  assign bus.done               = (state_q == DONE);
  assign bus.oaram_write_enable = wr_en_q;
  assign bus.oaram_value        = wr_value_q;
  assign bus.oaram_index        = wr_index_q;
  assign bus.oaram_address      = wr_addr_q;
  assign bus.entry_count        = cnt_q;
  assign bus.overflow           = ovf_q;
endmodule

// File: tb/tb_oa_compressor.sv
// Randomized scoreboard bench for oa_compressor: the stimulus side computes the
// expected OARAM entries of each channel and queues them; a negedge monitor
// pops one per write strobe.
module tb_oa_compressor;
  localparam int RW   = 10;
  localparam int IW   = 4;
  localparam int MAXR = 15;
  localparam int CAP  = 1 << RW;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  oa_compressor_if #(.RAM_WIDTH(RW), .INDEX_WIDTH(IW)) bus ();

  oa_compressor #(.RAM_WIDTH(RW), .INDEX_WIDTH(IW), .TILE_SIZE(128)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0]    v;
    logic [IW-1:0] idx;
    logic [RW-1:0] addr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] chan[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] relu(input logic [7:0] v);
`ifdef OA_RELU_EN
    return ($signed(v) < 0) ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  task automatic push(input logic [7:0] v, input int idx, inout int n);
    exp_t e;
    e.v    = v;
    e.idx  = IW'(idx);
    e.addr = RW'(n);
    if (n < CAP) sb.push_back(e);
    n++;
  endtask

  // Reference: count pending zeros; a nonzero closes the gap, and the
  // (MAXR+1)-th consecutive zero becomes a run-overflow entry.
  task automatic model(output int n);
    int z;
    z = 0;
    n = 0;
    foreach (chan[i]) begin
      logic [7:0] v;
      v = relu(chan[i]);
      if (v != 8'h00) begin
        push(v, z, n);
        z = 0;
      end else begin
        z++;
        if (z == MAXR + 1) begin
          push(8'h00, MAXR, n);
          z = 0;
        end
      end
    end
  endtask

  // Monitor: every write strobe must match the next expected entry.
  always @(negedge clk) begin
    if (reset_n && bus.oaram_write_enable) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got v=%0h idx=%0d addr=%0d want none",
                 bus.oaram_value, bus.oaram_index, bus.oaram_address);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_value", 32'(bus.oaram_value), 32'(e.v));
        check("wr_index", 32'(bus.oaram_index), 32'(e.idx));
        check("wr_addr",  32'(bus.oaram_address), 32'(e.addr));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(bus.oaram_write_enable), 0);
    check({tag, "_value"}, 32'(bus.oaram_value), 0);
    check({tag, "_index"}, 32'(bus.oaram_index), 0);
    check({tag, "_addr"},  32'(bus.oaram_address), 0);
    check({tag, "_count"}, 32'(bus.entry_count), 0);
    check({tag, "_ovf"},   32'(bus.overflow), 0);
    check({tag, "_done"},  32'(bus.done), 0);
    check({tag, "_ready"}, 32'(bus.dense_ready), 0);
  endtask

  // Start a channel and stream chan with random bubbles and stray starts.
  task automatic run_channel(input string tag, input bit has_last);
    int n, i, guard;
    bit fire, fire_last;
    model(n);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.dense_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_ready"}, 32'(bus.dense_ready), 1);
    check({tag, "_done_lo"}, 32'(bus.done), 0);
    i = 0;
    guard = 0;
    while (i < chan.size() && guard < 20000) begin
      bus.dense_valid = ($urandom_range(0, 3) != 0);
      bus.dense_value = bus.dense_valid ? chan[i] : 8'($urandom);
      bus.dense_last  = bus.dense_valid ? (has_last && i == chan.size() - 1)
                                        : 1'($urandom);
      bus.start       = ($urandom_range(0, 7) == 0);
      fire      = bus.dense_valid && bus.dense_ready;
      fire_last = fire && bus.dense_last;
      @(posedge clk); #1;
      if (fire) i++;
      if (fire_last) check({tag, "_done_rise"}, 32'(bus.done), 1);
      guard++;
    end
    check({tag, "_beats"}, 32'(i), 32'(chan.size()));
    bus.dense_valid = 1'b0;
    bus.dense_last  = 1'b0;
    bus.start       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_sb_drain"}, 32'(sb.size()), 0);
    if (has_last) begin
      check({tag, "_count"}, 32'(bus.entry_count), 32'((n < CAP) ? n : CAP));
      check({tag, "_ovf"},   32'(bus.overflow), 32'(n > CAP));
      check({tag, "_done"},  32'(bus.done), 1);
      check({tag, "_ready_lo"}, 32'(bus.dense_ready), 0);
    end
    sb.delete();
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.dense_value = 8'h00;
    bus.dense_valid = 1'b0;
    bus.dense_last  = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    chan = {8'd5, 8'd0, 8'd0, 8'd7, 8'h09};
    run_channel("basic", 1'b1);

    chan.delete();
    repeat (20) chan.push_back(8'd0);
    chan.push_back(8'd3);
    run_channel("z20", 1'b1);

    chan.delete();
    repeat (16) chan.push_back(8'd0);
    run_channel("z16", 1'b1);

    chan = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_channel("z5", 1'b1);

    chan = {8'hFE, 8'h04};
    run_channel("neg", 1'b1);

    chan = {8'h80, 8'h00, 8'hFF, 8'h01};
    run_channel("hi", 1'b1);

    // More nonzero beats than OARAM capacity.
    chan.delete();
    repeat (CAP + 6) chan.push_back(8'($urandom_range(1, 127)));
    run_channel("full", 1'b1);

    for (int k = 0; k < 8; k++) begin
      int len;
      len = $urandom_range(1, 80);
      chan.delete();
      repeat (len) chan.push_back(($urandom_range(0, 9) < 7) ? 8'h00 : 8'($urandom));
      run_channel("rand", 1'b1);
    end

    // Abort mid-channel after two entries, then start afresh.
    chan = {8'd1, 8'd2};
    run_channel("part", 1'b0);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk); #1 reset_n = 1'b1;
    chan = {8'd1};
    run_channel("after", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
